// File: rtl/text_console.sv
// text_console: byte-stream front end for the text VRAM CPU port.
// Interprets CR/LF/BS/FF, maintains a cursor, writes glyph codes, and
// scrolls or clears the screen through read/copy/write sequences on the
// single VRAM port. Outputs are decoded from registered state only.
module text_console #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_WIDTH = 13,
    parameter int COL_WIDTH  = 7,
    parameter int ROW_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_char,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic [7:0]            vram_rdata,
    output logic [COL_WIDTH-1:0]  cursor_col,
    output logic [ROW_WIDTH-1:0]  cursor_row,
    output logic                  busy
);

    // Geometry constants, all sized to the register they are compared with.
    localparam logic [COL_WIDTH-1:0]  LAST_COL    = COL_WIDTH'(COLS - 1);
    localparam logic [ROW_WIDTH-1:0]  LAST_ROW    = ROW_WIDTH'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] COLS_A      = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] COPY_LAST   = ADDR_WIDTH'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] BOTTOM_ROW  = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [ADDR_WIDTH-1:0] SCREEN_LAST = ADDR_WIDTH'(COLS * ROWS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_CLEAR
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_char,  w_char_nxt;
    logic [COL_WIDTH-1:0]  r_col,   w_col_nxt;
    logic [ROW_WIDTH-1:0]  r_row,   w_row_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr,   w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_end,   w_end_nxt;

    logic                  w_printable;
    logic [ADDR_WIDTH-1:0] w_cursor_addr;

    // Everything from 0x20 upward, including 0x7F-0xFF, is a glyph.
    assign w_printable   = (r_char >= CH_SPACE);
    // Parameter constraints keep row*COLS+col inside ADDR_WIDTH bits.
    assign w_cursor_addr = ADDR_WIDTH'(r_row) * COLS_A + ADDR_WIDTH'(r_col);

    assign cursor_col = r_col;
    assign cursor_row = r_row;

    // State and datapath registers; reset aborts any scroll or clear at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
            r_char  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_ptr   <= '0;
            r_end   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_char  <= w_char_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_ptr   <= w_ptr_nxt;
            r_end   <= w_end_nxt;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        // NOTE: every variable is defaulted first so no path can infer a latch.
        w_state_nxt = r_state;
        w_char_nxt  = r_char;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_ptr_nxt   = r_ptr;
        w_end_nxt   = r_end;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_char_nxt  = in_char;
                    w_state_nxt = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_state_nxt = ST_IDLE;
                if (r_char == CH_CR) begin
                    w_col_nxt = '0;
                end else if (r_char == CH_LF) begin
                    w_col_nxt = '0;
                    if (r_row < LAST_ROW) begin
                        w_row_nxt = r_row + 1'b1;
                    end else begin
                        w_ptr_nxt   = '0;
                        w_state_nxt = ST_SCROLL_RD;
                    end
                end else if (r_char == CH_BS) begin
                    if (r_col != '0) begin
                        w_col_nxt = r_col - 1'b1;
                    end
                end else if (r_char == CH_FF) begin
                    w_ptr_nxt   = '0;
                    w_end_nxt   = SCREEN_LAST;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = ST_CLEAR;
                end else if (w_printable) begin
                    if (r_col < LAST_COL) begin
                        w_col_nxt = r_col + 1'b1;
                    end else begin
                        w_col_nxt = '0;
                        if (r_row < LAST_ROW) begin
                            w_row_nxt = r_row + 1'b1;
                        end else begin
                            w_ptr_nxt   = '0;
                            w_state_nxt = ST_SCROLL_RD;
                        end
                    end
                end
            end

            ST_SCROLL_RD: begin
                w_state_nxt = ST_SCROLL_WR;
            end

            ST_SCROLL_WR: begin
                if (r_ptr == COPY_LAST) begin
                    // Copy finished; blank the freshly exposed bottom row.
                    w_ptr_nxt   = BOTTOM_ROW;
                    w_end_nxt   = SCREEN_LAST;
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_ptr_nxt   = r_ptr + 1'b1;
                    w_state_nxt = ST_SCROLL_RD;
                end
            end

            ST_CLEAR: begin
                if (r_ptr == r_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; held quiet while reset is asserted.
    always_comb begin
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        in_ready   = 1'b0;
        busy       = 1'b0;

        if (!rst) begin
            in_ready = (r_state == ST_IDLE);
            busy     = (r_state != ST_IDLE);
            case (r_state)
                ST_EXEC: begin
                    if (w_printable && (r_char != CH_BS) && (r_char != CH_LF)) begin
                        vram_we    = 1'b1;
                        vram_addr  = w_cursor_addr;
                        vram_wdata = r_char;
                    end
                end
                ST_SCROLL_RD: begin
                    // Source is one row below the destination.
                    vram_addr = r_ptr + COLS_A;
                end
                ST_SCROLL_WR: begin
                    // Read data for ptr+COLS arrives this cycle.
                    vram_we    = 1'b1;
                    vram_addr  = r_ptr;
                    vram_wdata = vram_rdata;
                end
                ST_CLEAR: begin
                    vram_we    = 1'b1;
                    vram_addr  = r_ptr;
                    vram_wdata = CH_SPACE;
                end
                default: begin
                    vram_we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: a behavioural VRAM plus a
// screen/cursor reference model applied to directed and random bytes.
module tb_text_console;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'h00;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    text_console #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(13), .COL_WIDTH(7), .ROW_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural VRAM: synchronous read, bench-side preload port.
    logic [7:0]  vmem [0:CELLS-1];
    logic        bk_we = 1'b0;
    int          bk_addr = 0;
    logic [7:0]  bk_data = 8'h00;

    always @(posedge clk) begin
        if (bk_we) vmem[bk_addr] <= bk_data;
        else if (vram_we && int'(vram_addr) < CELLS) vmem[vram_addr] <= vram_wdata;
        vram_rdata <= (int'(vram_addr) < CELLS) ? vmem[vram_addr] : 8'h00;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int addr; logic [7:0] data;} wr_t;
    wr_t wlog[$];
    always @(negedge clk) if (vram_we) wlog.push_back('{int'(vram_addr), vram_wdata});

    // Reference model.
    logic [7:0] ref_scr [0:CELLS-1];
    logic [7:0] old_scr [0:CELLS-1];
    int ref_col = 0;
    int ref_row = 0;

    int n_vec = 0;
    int n_err = 0;
    int last_accept = 0;

    task automatic model_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) ref_scr[r*COLS + c] = ref_scr[(r+1)*COLS + c];
        for (int c = 0; c < COLS; c++) ref_scr[(ROWS-1)*COLS + c] = 8'h20;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0D) ref_col = 0;
        else if (b == 8'h0A) begin
            ref_col = 0;
            if (ref_row < ROWS - 1) ref_row++; else model_scroll();
        end else if (b == 8'h08) begin
            if (ref_col > 0) ref_col--;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) ref_scr[i] = 8'h20;
            ref_col = 0; ref_row = 0;
        end else if (b >= 8'h20) begin
            ref_scr[ref_row*COLS + ref_col] = b;
            ref_col++;
            if (ref_col == COLS) begin
                ref_col = 0;
                if (ref_row < ROWS - 1) ref_row++; else model_scroll();
            end
        end
    endtask

    task automatic preload(input bit random_fill, input bit row1_55);
        logic [7:0] v;
        for (int i = 0; i < CELLS; i++) begin
            v = random_fill ? 8'($urandom_range(32, 255)) : 8'h20;
            if (row1_55 && i >= COLS && i < 2*COLS) v = 8'h55;
            bk_we = 1'b1; bk_addr = i; bk_data = v;
            ref_scr[i] = v;
            @(posedge clk); #1;
        end
        bk_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1; in_char = b;
        @(negedge clk);
        while (!in_ready && t < 20000) begin @(negedge clk); t++; end
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
            n_err++; n_vec++;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        last_accept = cyc;
        #1 in_valid = 1'b0;
    endtask

    // Edges from the accepting edge until in_ready is seen high again.
    task automatic wait_ready(input int budget, output int k);
        k = 0;
        do begin @(posedge clk); k++; #1; end while (!in_ready && k < budget);
        if (!in_ready) begin
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles", in_ready, k);
            n_err++; n_vec++;
        end
    endtask

    task automatic check_cursor(input string name);
        n_vec++;
        if (cursor_col !== 7'(ref_col) || cursor_row !== 6'(ref_row)) begin
            $display("FAIL %s: cursor (%0d,%0d) required (%0d,%0d)", name,
                     cursor_col, cursor_row, ref_col, ref_row);
            n_err++;
        end
    endtask

    task automatic compare_screen(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < CELLS; i++)
            if (vmem[i] !== ref_scr[i]) begin bad++; if (first < 0) first = i; end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL %s: %0d cells differ, first addr %0d got %h required %h",
                     name, bad, first, vmem[first], ref_scr[first]);
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b0 || vram_we !== 1'b0 || busy !== 1'b0 || vram_addr !== 13'd0) begin
            $display("FAIL reset_outputs: ready=%b we=%b busy=%b addr=%0d required 0 0 0 0",
                     in_ready, vram_we, busy, vram_addr);
            n_err++;
        end
        ref_col = 0; ref_row = 0;
        check_cursor("reset_cursor");
        @(posedge clk); #1 rst = 1'b0; #1;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release: ready=%b busy=%b required 1 0", in_ready, busy);
            n_err++;
        end
    endtask

    task automatic test_glyphs();
        int k;
        logic [7:0] chars [2];
        chars[0] = 8'h41; chars[1] = 8'h42;
        wlog.delete();
        for (int i = 0; i < 2; i++) begin
            send_byte(chars[i]);
            n_vec++;
            if (in_ready !== 1'b0) begin
                $display("FAIL glyph_ready_low: in_ready=%b required 0", in_ready); n_err++;
            end
            wait_ready(10, k);
            n_vec++;
            if (k != 1) begin
                $display("FAIL glyph_ready_gap: low for %0d cycles required 1", k); n_err++;
            end
            model_byte(chars[i]);
        end
        n_vec++;
        if (wlog.size() != 2 || wlog[0].addr != 0 || wlog[0].data !== 8'h41 ||
            wlog[1].addr != 1 || wlog[1].data !== 8'h42) begin
            $display("FAIL glyph_writes: %0d writes, first addr %0d data %h, required (0,41),(1,42)",
                     wlog.size(), (wlog.size() > 0) ? wlog[0].addr : -1,
                     (wlog.size() > 0) ? wlog[0].data : 8'h00);
            n_err++;
        end
        check_cursor("glyph_cursor");
    endtask

    task automatic test_wrap_cr_bs();
        int k;
        int bad;
        logic [7:0] b;
        logic [7:0] sent [COLS];
        send_byte(8'h0D); wait_ready(10, k); model_byte(8'h0D);
        check_cursor("cr_to_col0");
        wlog.delete();
        for (int i = 0; i < COLS; i++) begin
            b = 8'($urandom_range(32, 255));
            sent[i] = b;
            send_byte(b); wait_ready(10, k); model_byte(b);
        end
        bad = 0;
        for (int i = 0; i < COLS && i < wlog.size(); i++)
            if (wlog[i].addr != i || wlog[i].data !== sent[i]) bad++;
        n_vec++;
        if (wlog.size() != COLS || bad != 0 || wlog[wlog.size()-1].addr != COLS - 1) begin
            $display("FAIL row_fill: %0d writes %0d wrong, last addr %0d required 80 writes ending 79",
                     wlog.size(), bad, (wlog.size() > 0) ? wlog[wlog.size()-1].addr : -1);
            n_err++;
        end
        check_cursor("wrap_to_next_row");
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(32, 126));
            send_byte(b); wait_ready(10, k); model_byte(b);
        end
        check_cursor("col5");
        wlog.delete();
        send_byte(8'h0D); wait_ready(10, k); model_byte(8'h0D);
        check_cursor("cr_mid_row");
        send_byte(8'h08); wait_ready(10, k); model_byte(8'h08);
        check_cursor("bs_at_col0");
        n_vec++;
        if (wlog.size() != 0) begin
            $display("FAIL cr_bs_no_write: %0d writes required 0", wlog.size()); n_err++;
        end
        send_byte(8'h21); wait_ready(10, k); model_byte(8'h21);
        send_byte(8'h08); wait_ready(10, k); model_byte(8'h08);
        check_cursor("bs_decrement");
        compare_screen("screen_after_wrap");
    endtask

    task automatic test_ctrl_ignore();
        int k;
        logic [7:0] codes [2];
        codes[0] = 8'h07; codes[1] = 8'h1B;
        for (int i = 0; i < 3; i++) begin send_byte(8'h2A); wait_ready(10, k); model_byte(8'h2A); end
        for (int i = 0; i < 2; i++) begin
            wlog.delete();
            send_byte(codes[i]); wait_ready(10, k); model_byte(codes[i]);
            n_vec++;
            if (k != 1 || wlog.size() != 0) begin
                $display("FAIL ctrl_ignore_%h: ready gap %0d writes %0d required 1 and 0",
                         codes[i], k, wlog.size());
                n_err++;
            end
            check_cursor("ctrl_cursor");
        end
    endtask

    task automatic test_random();
        int k;
        int r;
        int exp_addr;
        logic [7:0] b;
        logic [7:0] ctl [4];
        ctl[0] = 8'h01; ctl[1] = 8'h07; ctl[2] = 8'h1B; ctl[3] = 8'h1F;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5 && ref_row < ROWS - 2) b = 8'h0A;
            else if (r < 8)  b = 8'h0D;
            else if (r < 12) b = 8'h08;
            else if (r < 15) b = ctl[$urandom_range(0, 3)];
            else             b = 8'($urandom_range(32, 255));
            exp_addr = ref_row*COLS + ref_col;
            wlog.delete();
            send_byte(b); wait_ready(10, k);
            n_vec++;
            if (b >= 8'h20) begin
                if (wlog.size() != 1 || wlog[0].addr != exp_addr || wlog[0].data !== b) begin
                    $display("FAIL rand_write byte %h: %0d writes addr %0d required one write addr %0d",
                             b, wlog.size(), (wlog.size() > 0) ? wlog[0].addr : -1, exp_addr);
                    n_err++;
                end
            end else if (wlog.size() != 0) begin
                $display("FAIL rand_nowrite byte %h: %0d writes required 0", b, wlog.size());
                n_err++;
            end
            model_byte(b);
            check_cursor("rand_cursor");
        end
        compare_screen("screen_after_random");
    endtask

    task automatic test_scroll();
        int k;
        int bad;
        int bad55;
        preload(1'b1, 1'b1);
        while (ref_row < ROWS - 1) begin
            send_byte(8'h0A); wait_ready(10, k); model_byte(8'h0A);
        end
        check_cursor("at_last_row");
        for (int i = 0; i < CELLS; i++) old_scr[i] = ref_scr[i];
        wlog.delete();
        send_byte(8'h0A);
        wait_ready(12000, k);
        n_vec++;
        if (k != 1 + 2*(ROWS-1)*COLS + COLS) begin
            $display("FAIL scroll_duration: %0d cycles required %0d", k, 1 + 2*(ROWS-1)*COLS + COLS);
            n_err++;
        end
        bad = 0; bad55 = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i].addr != i) bad++;
            else if (i < (ROWS-1)*COLS && wlog[i].data !== old_scr[i + COLS]) bad++;
            else if (i >= (ROWS-1)*COLS && wlog[i].data !== 8'h20) bad++;
            if (i < COLS && wlog[i].data !== 8'h55) bad55++;
        end
        n_vec++;
        if (wlog.size() != CELLS || bad != 0) begin
            $display("FAIL scroll_writes: %0d writes %0d wrong required %0d in order", wlog.size(), bad, CELLS);
            n_err++;
        end
        n_vec++;
        if (bad55 != 0 || wlog.size() < COLS) begin
            $display("FAIL scroll_row0_55: %0d of row 0 not 55", bad55); n_err++;
        end
        model_byte(8'h0A);
        check_cursor("scroll_cursor");
        compare_screen("screen_after_scroll");
    endtask

    task automatic test_reset_mid_scroll();
        send_byte(8'h0A);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        wlog.delete();
        @(negedge clk);
        n_vec++;
        if (vram_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL midreset_outputs: we=%b ready=%b busy=%b required 0 0 0", vram_we, in_ready, busy);
            n_err++;
        end
        @(posedge clk); #1 rst = 1'b0; #1;
        ref_col = 0; ref_row = 0;
        check_cursor("midreset_cursor");
        repeat (40) @(posedge clk); #1;
        n_vec++;
        if (wlog.size() != 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midreset_quiet: writes=%0d busy=%b ready=%b required 0 0 1", wlog.size(), busy, in_ready);
            n_err++;
        end
    endtask

    task automatic test_ff();
        int k;
        int bad;
        send_byte(8'h33); wait_ready(10, k); model_byte(8'h33);
        wlog.delete();
        send_byte(8'h0C);
        wait_ready(6000, k);
        n_vec++;
        if (k != 1 + CELLS) begin
            $display("FAIL ff_duration: %0d cycles required %0d", k, 1 + CELLS); n_err++;
        end
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i].addr != i || wlog[i].data !== 8'h20) bad++;
        n_vec++;
        if (wlog.size() != CELLS || bad != 0) begin
            $display("FAIL ff_writes: %0d writes %0d wrong required %0d blanks in order", wlog.size(), bad, CELLS);
            n_err++;
        end
        model_byte(8'h0C);
        check_cursor("ff_cursor");
        compare_screen("screen_after_ff");
    endtask

    task automatic test_back_to_back();
        int k;
        int prev;
        logic [7:0] chars [3];
        chars[0] = 8'h58; chars[1] = 8'h59; chars[2] = 8'h5A;
        wlog.delete();
        send_byte(chars[0]); prev = last_accept; model_byte(chars[0]);
        for (int i = 1; i < 3; i++) begin
            send_byte(chars[i]); model_byte(chars[i]);
            n_vec++;
            if (last_accept - prev != 2) begin
                $display("FAIL b2b_spacing: %0d cycles between accepts required 2", last_accept - prev);
                n_err++;
            end
            prev = last_accept;
        end
        wait_ready(10, k);
        n_vec++;
        if (wlog.size() != 3 || wlog[0].addr != 0 || wlog[1].addr != 1 || wlog[2].addr != 2 ||
            wlog[2].data !== 8'h5A) begin
            $display("FAIL b2b_writes: %0d writes required 3 at addr 0..2", wlog.size()); n_err++;
        end
        check_cursor("b2b_cursor");
        compare_screen("screen_after_b2b");
    endtask

    initial begin
        test_reset();
        preload(1'b0, 1'b0);
        test_glyphs();
        test_wrap_cr_bs();
        test_ctrl_ignore();
        test_random();
        test_scroll();
        test_reset_mid_scroll();
        test_ff();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
